// File: rtl/int8_mac_pkg.sv
// int8_mac_pkg: shared FSM state type and constants for the int8 MAC sequencer.
// Buffer read latency is fixed by the M10K operand buffers upstream.
package int8_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_ITE_NUM    = 100;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_ACC_WIDTH  = 32;

    localparam int RD_LAT    = 2;
    localparam int VLD_DEPTH = RD_LAT;

endpackage

// File: rtl/int8_mac_seq_if.sv
// int8_mac_seq_if: operand buffer read port plus valid/ready result port.
// master = MAC sequencer, slave = buffers/consumer side.
interface int8_mac_seq_if
    import int8_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) ();

    logic        [ADDR_WIDTH-1:0] raddr;
    logic signed [DATA_WIDTH-1:0] a_q;
    logic signed [DATA_WIDTH-1:0] w_q;
    logic signed [ACC_WIDTH-1:0]  result;
    logic                         result_valid;
    logic                         result_ready;

    modport master (
        output raddr,
        input  a_q,
        input  w_q,
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  raddr,
        output a_q,
        output w_q,
        input  result,
        input  result_valid,
        output result_ready
    );

endinterface

// File: rtl/int8_mac_acc.sv
// int8_mac_acc: signed multiply, sign-extend and accumulate with clear/enable.
// INT8_MAC_SAT_EN selects saturating addition; otherwise two's-complement wrap.
module int8_mac_acc
    import int8_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;

`ifdef INT8_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    always_comb begin
        prod     = a * w;
        prod_ext = ACC_WIDTH'(prod);
        sum      = acc_q + prod_ext;
`ifdef INT8_MAC_SAT_EN
        // Same-sign operands with a flipped result sign means overflow.
        if (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1] &&
            sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]) begin
            sum = acc_q[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/int8_mac_seq.sv
// int8_mac_seq: walks buffer addresses, aligns read data to RD_LAT and
// accumulates a signed dot product (saturation via INT8_MAC_SAT_EN in int8_mac_acc).
module int8_mac_seq
    import int8_mac_pkg::*;
#(
    parameter int ITE_NUM    = DEF_ITE_NUM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    int8_mac_seq_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ITE_NUM - 1);
    localparam logic [VLD_DEPTH-1:0]  VLD_LAST  = VLD_DEPTH'(1) << (VLD_DEPTH - 1);

    state_e                       state_q;
    state_e                       state_d;
    logic        [ADDR_WIDTH-1:0] raddr_q;
    logic        [ADDR_WIDTH-1:0] raddr_d;
    logic        [VLD_DEPTH-1:0]  vld_q;
    logic        [VLD_DEPTH-1:0]  vld_d;
    logic                         acc_clr;
    logic                         acc_en;
    logic signed [ACC_WIDTH-1:0]  acc;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        vld_d   = {vld_q[VLD_DEPTH-2:0], 1'b0};
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    raddr_d = '0;
                    acc_clr = 1'b1;
                end
            end
            FETCH: begin
                vld_d[0] = 1'b1;
                if (raddr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    raddr_d = raddr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Only the final read is left, and it is consumed this cycle.
                if (vld_q == VLD_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            vld_q   <= vld_d;
        end
    end

    assign acc_en = vld_q[VLD_DEPTH-1];

    int8_mac_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (bus.a_q),
        .w   (bus.w_q),
        .acc (acc)
    );

    assign busy             = (state_q != IDLE);
    assign bus.raddr        = raddr_q;
    assign bus.result       = acc;
    assign bus.result_valid = (state_q == DONE);

endmodule

// File: tb/tb_int8_mac_seq.sv
// tb_int8_mac_seq: scoreboard bench over three int8_mac_seq configurations.
// Expected dot products are queued at start; negedge monitors pop on handshake.
module tb_int8_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic start4;
    logic start100;
    logic start16;
    logic busy4;
    logic busy100;
    logic busy16;

    int checks = 0;
    int errors = 0;

    longint q4[$];
    longint q100[$];
    longint q16[$];

    int8_mac_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(32)) if4 ();
    int8_mac_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(32)) if100 ();
    int8_mac_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(16)) if16 ();

    int8_mac_seq #(.ITE_NUM(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(32)) u4 (
        .clk   (clk),
        .rst   (rst_a),
        .start (start4),
        .busy  (busy4),
        .bus   (if4)
    );

    int8_mac_seq #(.ITE_NUM(100), .DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(32)) u100 (
        .clk   (clk),
        .rst   (rst_b),
        .start (start100),
        .busy  (busy100),
        .bus   (if100)
    );

    int8_mac_seq #(.ITE_NUM(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .ACC_WIDTH(16)) u16 (
        .clk   (clk),
        .rst   (rst_b),
        .start (start16),
        .busy  (busy16),
        .bus   (if16)
    );

    // Two-cycle buffer model for the 4-entry instance
    logic signed [7:0] mem_a[4];
    logic signed [7:0] mem_w[4];
    logic signed [7:0] a_s1;
    logic signed [7:0] w_s1;

    always @(posedge clk) begin
        a_s1     <= mem_a[if4.raddr[1:0]];
        w_s1     <= mem_w[if4.raddr[1:0]];
        if4.a_q  <= a_s1;
        if4.w_q  <= w_s1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic vld_of(input int which);
        case (which)
            0:       return if4.result_valid;
            1:       return if100.result_valid;
            default: return if16.result_valid;
        endcase
    endfunction

    task automatic wait_valid(input int which, input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (!vld_of(which) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!vld_of(which)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%0d: got no result_valid expected within %0d cycles",
                     which, max_cyc);
        end
    endtask

    task automatic set_mem(input logic signed [7:0] a0, input logic signed [7:0] a1,
                           input logic signed [7:0] a2, input logic signed [7:0] a3,
                           input logic signed [7:0] w0, input logic signed [7:0] w1,
                           input logic signed [7:0] w2, input logic signed [7:0] w3);
        mem_a[0] = a0; mem_a[1] = a1; mem_a[2] = a2; mem_a[3] = a3;
        mem_w[0] = w0; mem_w[1] = w1; mem_w[2] = w2; mem_w[3] = w3;
    endtask

    task automatic run4(input longint exp);
        q4.push_back(exp);
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        wait_valid(0, 20);
        cyc();
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst_a && if4.result_valid && if4.result_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dot4_extra: got %0d expected no result", if4.result);
            end else begin
                chk("dot4", if4.result, q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && if100.result_valid && if100.result_ready) begin
            if (q100.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dot100_extra: got %0d expected no result", if100.result);
            end else begin
                chk("dot100", if100.result, q100.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && if16.result_valid && if16.result_ready) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dot16_extra: got %0d expected no result", if16.result);
            end else begin
                chk("dot16", if16.result, q16.pop_front());
            end
        end
    end

    initial begin
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        start4   = 1'b0;
        start100 = 1'b0;
        start16  = 1'b0;
        if4.result_ready   = 1'b1;
        if100.result_ready = 1'b1;
        if16.result_ready  = 1'b1;
        if100.a_q = -8'sd128;
        if100.w_q = -8'sd128;
        if16.a_q  = 8'sd127;
        if16.w_q  = 8'sd127;
        set_mem(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (3) cyc();
        rst_a = 1'b0;
        rst_b = 1'b0;

        @(negedge clk);
        chk("reset_busy", busy4, 0);
        chk("reset_raddr", if4.raddr, 0);
        chk("reset_result", if4.result, 0);
        chk("reset_valid", if4.result_valid, 0);
        cyc();

        // Basic run with cycle-accurate address and valid timing
        q4.push_back(70);
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 4) chk("raddr_seq", if4.raddr, k - 1);
            chk("valid_cycle", if4.result_valid, (k == 7));
            if (k == 1) chk("busy_rise", busy4, 1);
            cyc();
        end

        // Mixed signs: -127 + 16384 - 127 + 0
        set_mem(-1, -128, 127, 0, 127, -128, -1, 55);
        run4(16130);
        set_mem(1, 2, 3, 4, 5, 6, 7, 8);

        // Backpressure with dropped start pulses
        if4.result_ready = 1'b0;
        q4.push_back(70);
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        cyc();
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        wait_valid(0, 20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", if4.result_valid, 1);
            chk("hold_result", if4.result, 70);
            cyc();
            start4 = (i == 1 || i == 2);
            @(negedge clk);
        end
        cyc();
        start4 = 1'b0;
        if4.result_ready = 1'b1;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("idle_after_ack", busy4, 0);
        chk("valid_after_ack", if4.result_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("start_dropped", busy4, 0);
        end
        cyc();

        // Reset in cycle 2 of a run
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        cyc();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy4, 0);
        chk("midrst_raddr", if4.raddr, 0);
        chk("midrst_valid", if4.result_valid, 0);
        cyc();
        run4(70);

        // Back-to-back: start right after the handshake cycle
        q4.push_back(70);
        q4.push_back(70);
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        wait_valid(0, 20);
        cyc();
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        wait_valid(0, 20);
        cyc();

        // Negative extremes, 100 products
        q100.push_back(1638400);
        start100 = 1'b1;
        cyc();
        start100 = 1'b0;
        wait_valid(1, 200);
        cyc();
        if100.w_q = 8'sd127;
        q100.push_back(-1625600);
        start100 = 1'b1;
        cyc();
        start100 = 1'b0;
        wait_valid(1, 200);
        cyc();

        // 16-bit accumulator overflow: 4 * 16129 = 64516
`ifdef INT8_MAC_SAT_EN
        q16.push_back(32767);
`else
        q16.push_back(-1020);
`endif
        start16 = 1'b1;
        cyc();
        start16 = 1'b0;
        wait_valid(2, 20);
        cyc();

        repeat (3) cyc();
        chk("q4_empty", q4.size(), 0);
        chk("q100_empty", q100.size(), 0);
        chk("q16_empty", q16.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
